// File: rtl/kb_ascii_decoder.sv
// kb_ascii_decoder
// PS/2 set-2 scan-code to ASCII decoder with a first-word-fall-through output
// queue. Tracks break/extended prefixes, both shift keys and caps-lock, and
// pushes case- and shift-correct ASCII into a 2^W_DEPTH entry FIFO.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_scan_code   received scan byte, qualified by i_scan_valid
//   i_scan_valid  one-cycle strobe per byte
//   i_rd          pop the head entry (ignored while empty)
//   o_ascii_code  FIFO head, 8'h00 while empty
//   o_empty       FIFO empty
//   o_full        FIFO full
//   o_drop        one-cycle pulse when a character was refused by a full FIFO
//   o_shift       either shift key held
//   o_caps        caps-lock toggle state
module kb_ascii_decoder #(
  parameter int W_DEPTH = 3,
  parameter bit CAPS_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_scan_code,
  input  logic       i_scan_valid,
  input  logic       i_rd,
  output logic [7:0] o_ascii_code,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_drop,
  output logic       o_shift,
  output logic       o_caps
);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  localparam int DEPTH = 1 << W_DEPTH;
  localparam logic [W_DEPTH:0] PTR_ONE = {{W_DEPTH{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             lshift_q, lshift_d;
  logic             rshift_q, rshift_d;
  logic             caps_q, caps_d;
  logic             caps_held_q, caps_held_d;
  logic             drop_q, drop_d;
  logic [W_DEPTH:0] wr_ptr_q, wr_ptr_d;
  logic [W_DEPTH:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [DEPTH];

  logic       push;
  logic [7:0] push_ch;
  logic [8:0] xlat;
  logic       empty, full, pop, wr_en;

  // Returns {mapped, ascii}. Letters follow shift XOR caps; digits and
  // symbols follow shift only; the fixed control codes ignore both.
  function automatic logic [8:0] translate(input logic [7:0] code,
                                           input logic shift,
                                           input logic caps);
    logic       hit, letter;
    logic [7:0] lo, hi, ch;
    hit = 1'b1; letter = 1'b0; lo = 8'h00; hi = 8'h00;
    case (code)
      8'h1C: begin letter = 1'b1; lo = 8'h61; end
      8'h32: begin letter = 1'b1; lo = 8'h62; end
      8'h21: begin letter = 1'b1; lo = 8'h63; end
      8'h23: begin letter = 1'b1; lo = 8'h64; end
      8'h24: begin letter = 1'b1; lo = 8'h65; end
      8'h2B: begin letter = 1'b1; lo = 8'h66; end
      8'h34: begin letter = 1'b1; lo = 8'h67; end
      8'h33: begin letter = 1'b1; lo = 8'h68; end
      8'h43: begin letter = 1'b1; lo = 8'h69; end
      8'h3B: begin letter = 1'b1; lo = 8'h6A; end
      8'h42: begin letter = 1'b1; lo = 8'h6B; end
      8'h4B: begin letter = 1'b1; lo = 8'h6C; end
      8'h3A: begin letter = 1'b1; lo = 8'h6D; end
      8'h31: begin letter = 1'b1; lo = 8'h6E; end
      8'h44: begin letter = 1'b1; lo = 8'h6F; end
      8'h4D: begin letter = 1'b1; lo = 8'h70; end
      8'h15: begin letter = 1'b1; lo = 8'h71; end
      8'h2D: begin letter = 1'b1; lo = 8'h72; end
      8'h1B: begin letter = 1'b1; lo = 8'h73; end
      8'h2C: begin letter = 1'b1; lo = 8'h74; end
      8'h3C: begin letter = 1'b1; lo = 8'h75; end
      8'h2A: begin letter = 1'b1; lo = 8'h76; end
      8'h1D: begin letter = 1'b1; lo = 8'h77; end
      8'h22: begin letter = 1'b1; lo = 8'h78; end
      8'h35: begin letter = 1'b1; lo = 8'h79; end
      8'h1A: begin letter = 1'b1; lo = 8'h7A; end
      8'h45: begin lo = 8'h30; hi = 8'h29; end
      8'h16: begin lo = 8'h31; hi = 8'h21; end
      8'h1E: begin lo = 8'h32; hi = 8'h40; end
      8'h26: begin lo = 8'h33; hi = 8'h23; end
      8'h25: begin lo = 8'h34; hi = 8'h24; end
      8'h2E: begin lo = 8'h35; hi = 8'h25; end
      8'h36: begin lo = 8'h36; hi = 8'h5E; end
      8'h3D: begin lo = 8'h37; hi = 8'h26; end
      8'h3E: begin lo = 8'h38; hi = 8'h2A; end
      8'h46: begin lo = 8'h39; hi = 8'h28; end
      8'h0E: begin lo = 8'h60; hi = 8'h7E; end
      8'h4E: begin lo = 8'h2D; hi = 8'h5F; end
      8'h55: begin lo = 8'h3D; hi = 8'h2B; end
      8'h54: begin lo = 8'h5B; hi = 8'h7B; end
      8'h5B: begin lo = 8'h5D; hi = 8'h7D; end
      8'h5D: begin lo = 8'h5C; hi = 8'h7C; end
      8'h4C: begin lo = 8'h3B; hi = 8'h3A; end
      8'h52: begin lo = 8'h27; hi = 8'h22; end
      8'h41: begin lo = 8'h2C; hi = 8'h3C; end
      8'h49: begin lo = 8'h2E; hi = 8'h3E; end
      8'h4A: begin lo = 8'h2F; hi = 8'h3F; end
      8'h29: begin lo = 8'h20; hi = 8'h20; end
      8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
      8'h66: begin lo = 8'h08; hi = 8'h08; end
      8'h0D: begin lo = 8'h09; hi = 8'h09; end
      8'h76: begin lo = 8'h1B; hi = 8'h1B; end
      default: hit = 1'b0;
    endcase
    if (letter) ch = (shift ^ caps) ? (lo - 8'h20) : lo;
    else        ch = shift ? hi : lo;
    return {hit, ch};
  endfunction

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[W_DEPTH] != rd_ptr_q[W_DEPTH]) &&
                 (wr_ptr_q[W_DEPTH-1:0] == rd_ptr_q[W_DEPTH-1:0]);
  assign xlat  = translate(i_scan_code, lshift_q | rshift_q, caps_q);

  // Prefix FSM, modifier tracking and FIFO pointer bookkeeping. When full,
  // a simultaneous pop frees the head slot, so the push lands where the head
  // was and both pointers advance together.
  always_comb begin
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    push        = 1'b0;
    push_ch     = xlat[7:0];
    if (i_scan_valid) begin
      case (state_q)
        S_IDLE: begin
          if (i_scan_code == 8'hF0)      state_d = S_BRK;
          else if (i_scan_code == 8'hE0) state_d = S_EXT;
          else if (i_scan_code == 8'h12) lshift_d = 1'b1;
          else if (i_scan_code == 8'h59) rshift_d = 1'b1;
          else if (i_scan_code == 8'h58) begin
            // Only the first make toggles; typematic repeats are absorbed.
            if (CAPS_EN) begin
              if (!caps_held_q) caps_d = ~caps_q;
              caps_held_d = 1'b1;
            end
          end
          else push = xlat[8];
        end
        S_BRK: begin
          state_d = S_IDLE;
          if (i_scan_code == 8'h12)      lshift_d = 1'b0;
          else if (i_scan_code == 8'h59) rshift_d = 1'b0;
          else if (i_scan_code == 8'h58) caps_held_d = 1'b0;
        end
        S_EXT: begin
          if (i_scan_code == 8'hF0) state_d = S_EXT_BRK;
          else begin
            state_d = S_IDLE;
            if (i_scan_code == 8'h5A) begin push = 1'b1; push_ch = 8'h0D; end
            if (i_scan_code == 8'h4A) begin push = 1'b1; push_ch = 8'h2F; end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    pop      = i_rd & ~empty;
    wr_en    = push & (~full | pop);
    drop_d   = push & full & ~pop;
    wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop   ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      drop_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      drop_q      <= drop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q[W_DEPTH-1:0]] <= push_ch;
  end

  assign o_ascii_code = empty ? 8'h00 : mem_q[rd_ptr_q[W_DEPTH-1:0]];
  assign o_empty      = empty;
  assign o_full       = full;
  assign o_drop       = drop_q;
  assign o_shift      = lshift_q | rshift_q;
  assign o_caps       = caps_q;

endmodule

// File: doc/kb_ascii_decoder.md
# kb_ascii_decoder

Stateful PS/2 set-2 scan-code to ASCII decoder with a buffered output queue. It sits between the PS/2 byte receiver and the consumer: a UART TX, a text-mode display writer, or the CPU port. It tracks make/break/extended prefixes, shift and caps-lock state, and produces case-correct and shift-correct ASCII. Translated characters are queued in a parametrised first-word-fall-through (FWFT) FIFO.

## Interface
Parameters:
- W_DEPTH, 3: FIFO address width; the queue depth is 2^W_DEPTH entries.
- CAPS_EN, 1: when 1, caps-lock is honoured; when 0, the caps key is ignored and o_caps stays 0.

Ports:
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_scan_code  in  8  received scan byte; qualified by i_scan_valid.
- i_scan_valid  in  1  one-cycle strobe per byte; strobes on back-to-back cycles are legal.
- i_rd  in  1  pop the head entry; ignored while o_empty=1.
- o_ascii_code  out  8  head of the FIFO; 8'h00 while empty.
- o_empty  out  1  FIFO empty.
- o_full  out  1  FIFO full.
- o_drop  out  1  one-cycle pulse; a character was discarded because the FIFO was full.
- o_shift  out  1  left shift OR right shift is currently held.
- o_caps  out  1  caps-lock toggle state.

## Operation
Prefix FSM. Each state advances only on a cycle with i_scan_valid=1.
- IDLE:
  - 8'hF0 -> BRK.
  - 8'hE0 -> EXT.
  - Any other byte is a make code and is processed; the FSM stays in IDLE.
- BRK: any byte is a break code and is processed; -> IDLE.
- EXT:
  - 8'hF0 -> EXT_BRK.
  - 8'h5A pushes 8'h0D (keypad enter).
  - 8'h4A pushes 8'h2F (keypad /).
  - Any other byte is discarded.
  - For every byte other than 8'hF0 -> IDLE.
- EXT_BRK: any byte is discarded; -> IDLE.

Make processing:
- 8'h12 sets lshift; 8'h59 sets rshift. Nothing is pushed.
- 8'h58 with CAPS_EN=1: toggles caps only if caps_held=0, then sets caps_held. Typematic repeats of the caps key therefore do not re-toggle. Nothing is pushed.
- All other codes are translated. Mapped codes are pushed; unmapped codes are discarded silently (no push, no o_drop).

Break processing:
- 8'h12 clears lshift; 8'h59 clears rshift; 8'h58 clears caps_held.
- No break code ever pushes.

Translation. Define s = lshift|rshift.
- Letters: uppercase (8'h41-8'h5A) when s XOR caps is 1, otherwise lowercase (8'h61-8'h7A).
- Digits 0-9: unshifted 8'h30-8'h39. Shifted: ) ! @ # $ % ^ & * ( for 0 through 9 respectively.
- Symbols: the unshifted and shifted pairs are: ` ~, - _, = +, [ {, ] }, \ |, ; :, ' ", , <, . >, / ?. Caps does not affect symbols.
- Fixed codes, unaffected by shift and caps:
  - 8'h29 -> 8'h20 (space)
  - 8'h5A -> 8'h0D (enter)
  - 8'h66 -> 8'h08 (backspace)
  - 8'h0D -> 8'h09 (tab)
  - 8'h76 -> 8'h1B (escape)

FIFO:
- (W_DEPTH+1)-bit read and write pointers; both wrap modulo 2^(W_DEPTH+1).
- full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- Push while full and i_rd=0: the character is discarded, o_drop pulses, and the pointers are unchanged.
- Push while full and i_rd=1: both the push and the pop succeed; o_full stays 1.
- Push while empty and i_rd=1: i_rd is ignored; the entry is written and o_empty falls.
- Pop while empty: no effect.

## Timing
- Reset asserted, at any time, asynchronously forces:
  - FSM to IDLE.
  - lshift, rshift, caps, caps_held to 0.
  - Pointers to 0.
  - Outputs: o_empty=1, o_full=0, o_drop=0, o_shift=0, o_caps=0, o_ascii_code=8'h00.
  A partial prefix sequence is lost. Release is synchronous to i_clk.
- Translation is combinational from i_scan_code and the current state; the write occurs on the same edge that samples i_scan_valid.
- Latency: a strobe at edge N makes the character appear on o_ascii_code, with o_empty=0, after edge N.
- o_shift and o_caps update after the edge that samples the modifier byte, so they affect the next byte.
- i_rd at edge N advances the head; the next entry, or 8'h00 with o_empty=1, appears after edge N.
- o_drop is registered: it is high for exactly the cycle after the edge on which the push was refused.

## Test plan
- Reset, then strobe 8'h1C -> one entry 8'h61 ('a') after 1 cycle; i_rd -> o_empty=1, o_ascii_code=8'h00.
- Strobe 12, 16, F0, 12, 16 -> queue holds 8'h21 ('!') then 8'h31 ('1'); o_shift is 1 between the make and the break of 12.
- Strobe 58, 58, F0, 58, then 1C -> o_caps=1 (a single toggle) and 8'h41 pushed; then 12, 1C -> 8'h61 pushed (shift XOR caps).
- Strobe E0, 75, E0, F0, 75, E0, 5A, F0, 1C -> only 8'h0D is queued; the break of 1C pushes nothing; FSM ends in IDLE.
- W_DEPTH=3: 9 makes of 8'h29 with no reads -> o_full=1 after the 8th; the 9th gives a single o_drop pulse; 8 reads return 8'h20 each and o_empty=1 afterwards.
- Full FIFO with i_rd=1 and a simultaneous strobe of 8'h45 -> no drop, o_full stays 1, and 8'h30 is the last entry read; assert i_rst_n=0 mid-stream (after E0) -> all reset values hold; a subsequent 8'h1C yields 8'h61.
